// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//
// Parametrised inter-stage register chain. A packed payload moves through
// DEPTH register slots (slot 0 on the input side, slot DEPTH-1 drives the
// output), each slot carrying its own valid bit. Transfers use a valid/ready
// handshake. Empty slots (bubbles) collapse, so backpressure only reaches the
// input once every slot ahead of it is full. flush kills every in-flight beat.
//
// Optional feature (macro PIPE_STAGE_SKID_BUF_EN):
//   A one-entry skid register sits in front of slot 0. in_ready is then a
//   registered signal (~skid_valid) and total capacity becomes DEPTH+1.
//   Without the macro, in_ready is combinational from out_ready via the
//   ready chain.
//
// Parameters:
//   DATA_W     payload width (1..256)
//   DEPTH      number of register slots (1..8)
//   RESET_DATA value loaded into every data register on reset
//   CNT_W      occupancy width, derived from DEPTH (do not override)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; overrides flush and handshakes
//   flush      invalidate all slots (and the skid entry); data regs keep value
//   in_valid   upstream offers in_data
//   in_ready   block accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  last slot holds a valid payload
//   out_ready  downstream accepts this cycle
//   out_data   payload of the last slot
//   occupancy  number of valid entries held (slots plus skid entry)
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
  parameter int                 DATA_W     = 32,
  parameter int                 DEPTH      = 1,
  parameter logic [DATA_W-1:0]  RESET_DATA = {DATA_W{1'b0}},
  parameter int                 CNT_W      = $clog2(DEPTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  v_nxt;
  logic [DATA_W-1:0] d [DEPTH];

  // Per-slot advance enable and the (valid, data) pair each slot would load.
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  up_v;
  logic [DATA_W-1:0] up_d [DEPTH];

  // Source feeding slot 0: the input port, or the skid entry when present.
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              skid_cnt;
  logic [CNT_W-1:0]  occ_nxt;

  // ---------------------------------------------------------------------------
  // Ready chain: a slot may advance when downstream accepts or when any slot
  // at or ahead of it is empty. Accumulated in a variable rather than reading
  // adv back, so the chain is a plain OR-reduction with no self-reference.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic chain;
    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    adv   = '0;
    chain = out_ready | ~v[DEPTH-1];
    adv[DEPTH-1] = chain;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      chain  = chain | ~v[i];
      adv[i] = chain;
    end
  end

`ifdef PIPE_STAGE_SKID_BUF_EN
  logic              skid_valid;
  logic              skid_valid_nxt;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;

  // A beat accepted while slot 0 cannot move is parked in the skid entry.
  // While parked, in_ready is low, so the skid entry always has priority.
  assign skid_load = ~skid_valid & in_valid & ~adv[0] & ~flush;
  assign src_valid = skid_valid | in_valid;
  assign src_data  = skid_valid ? skid_data : in_data;
  assign in_ready  = ~skid_valid;

  always_comb begin
    skid_valid_nxt = skid_valid;
    if (flush) begin
      skid_valid_nxt = 1'b0;
    end else if (skid_valid) begin
      if (adv[0]) skid_valid_nxt = 1'b0;
    end else if (skid_load) begin
      skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_data  <= RESET_DATA;
    end else begin
      skid_valid <= skid_valid_nxt;
      if (skid_load) skid_data <= in_data;
    end
  end

  assign skid_cnt = skid_valid_nxt;
`else
  assign src_valid = in_valid;
  assign src_data  = in_data;
  assign in_ready  = adv[0];
  assign skid_cnt  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Upstream view of each slot: slot 0 sees the source, slot i sees slot i-1.
  // ---------------------------------------------------------------------------
  always_comb begin
    up_v    = '0;
    up_v[0] = src_valid;
    up_d[0] = src_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  // Next-state valid bits; flush discards both the incoming and the outgoing
  // beat by simply clearing everything.
  always_comb begin
    v_nxt = v;
    if (flush) begin
      v_nxt = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) v_nxt[i] = up_v[i];
      end
    end
  end

  // Occupancy is the population count of the next-state valid bits.
  always_comb begin
    occ_nxt = CNT_W'(skid_cnt);
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + CNT_W'(v_nxt[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      v         <= '0;
      occupancy <= '0;
    end else begin
      v         <= v_nxt;
      occupancy <= occ_nxt;
    end
  end

  // Data registers only load when a valid beat moves in; a bubble moving in
  // leaves the old value in place to avoid needless toggling.
  always_ff @(posedge clk) begin
    // NOTE: the data array is reset here only because out_data must read
    // RESET_DATA after reset; storage that needs no defined value would skip it.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= RESET_DATA;
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i] && up_v[i]) d[i] <= up_d[i];
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_chain
//
// Self-checking bench. Four chains (DEPTH 1..4) share one set of inputs; each
// table vector names the chain whose outputs it checks. Vectors are applied on
// the falling edge and outputs sampled 1 time unit later, so every expected
// value describes the registered state plus the combinational in_ready seen
// with that vector's inputs, before the next rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_chain;

  localparam int W = 16;

`ifdef PIPE_STAGE_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         ir1, ir2, ir3, ir4;
  logic         ov1, ov2, ov3, ov4;
  logic [W-1:0] od1, od2, od3, od4;
  logic [1:0]   oc1, oc2;
  logic [2:0]   oc3, oc4;

  always #5 clk = ~clk;

  pipe_stage_chain #(.DATA_W(W), .DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(oc1));
  pipe_stage_chain #(.DATA_W(W), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .occupancy(oc2));
  pipe_stage_chain #(.DATA_W(W), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
    .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
    .occupancy(oc3));
  pipe_stage_chain #(.DATA_W(W), .DEPTH(4), .RESET_DATA(16'hBEEF)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .occupancy(oc4));

  typedef struct {
    int           sel;
    bit           chk;
    bit           rst;
    bit           fl;
    bit           iv;
    logic [W-1:0] id;
    bit           ordy;
    bit           e_ir;
    bit           e_ov;
    logic [W-1:0] e_od;
    int           e_occ;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input int sel, input bit chk, input bit r, input bit fl,
                     input bit iv, input logic [W-1:0] id, input bit ordy,
                     input bit e_ir, input bit e_ov, input logic [W-1:0] e_od,
                     input int e_occ);
    vec_t t;
    t.sel = sel; t.chk = chk; t.rst = r; t.fl = fl; t.iv = iv; t.id = id;
    t.ordy = ordy; t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od; t.e_occ = e_occ;
    tbl.push_back(t);
  endtask

  // Two reset cycles; the second vector checks the post-reset state.
  task automatic add_rst(input int sel, input logic [W-1:0] e_od);
    add(sel, 0, 1, 0, 0, 16'h0, 0, 1, 0, 16'h0, 0);
    add(sel, 1, 1, 0, 0, 16'h0, 0, 1, 0, e_od, 0);
  endtask

  task automatic sample(input int sel, output bit ir, output bit ov,
                        output logic [W-1:0] od, output int occ);
    case (sel)
      1:       begin ir = ir1; ov = ov1; od = od1; occ = int'(oc1); end
      2:       begin ir = ir2; ov = ov2; od = od2; occ = int'(oc2); end
      3:       begin ir = ir3; ov = ov3; od = od3; occ = int'(oc3); end
      default: begin ir = ir4; ov = ov4; od = od4; occ = int'(oc4); end
    endcase
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    bit           s_ir, s_ov;
    logic [W-1:0] s_od;
    int           s_occ;
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_d;
    int           sent, rcvd, lat, max_occ;

    // Reset and stream, DEPTH=3: first accept at the edge after step 2,
    // out_valid after two further edges; the last slot keeps 0x12 once drained.
    add_rst(3, 16'h0);
    add(3, 1, 0, 0, 1, 16'h10, 1, 1, 0, 16'h0,  0);
    add(3, 1, 0, 0, 1, 16'h11, 1, 1, 0, 16'h0,  1);
    add(3, 1, 0, 0, 1, 16'h12, 1, 1, 0, 16'h0,  2);
    add(3, 1, 0, 0, 0, 16'h0,  1, 1, 1, 16'h10, 3);
    add(3, 1, 0, 0, 0, 16'h0,  1, 1, 1, 16'h11, 2);
    add(3, 1, 0, 0, 0, 16'h0,  1, 1, 1, 16'h12, 1);
    add(3, 1, 0, 0, 0, 16'h0,  1, 1, 0, 16'h12, 0);

    // Backpressure, DEPTH=2: A,B fill the chain; C waits (or is parked in
    // the skid entry), then all three drain in order.
    add_rst(2, 16'h0);
    add(2, 1, 0, 0, 1, 16'hA, 0, 1,    0, 16'h0, 0);
    add(2, 1, 0, 0, 1, 16'hB, 0, 1,    0, 16'h0, 1);
    add(2, 1, 0, 0, 1, 16'hC, 0, SKID, 1, 16'hA, 2);
    add(2, 1, 0, 0, 1, 16'hC, 0, 0,    1, 16'hA, SKID ? 3 : 2);
    add(2, 1, 0, 0, 1, 16'hC, 1, !SKID, 1, 16'hA, SKID ? 3 : 2);
    add(2, 1, 0, 0, 0, 16'h0, 1, 1,    1, 16'hB, 2);
    add(2, 1, 0, 0, 0, 16'h0, 1, 1,    1, 16'hC, 1);
    add(2, 1, 0, 0, 0, 16'h0, 1, 1,    0, 16'hC, 0);

    // Bubble collapse, DEPTH=3: 0x55 walks to slot 2 under a stall, 0x66 is
    // still accepted and closes up behind it.
    add_rst(3, 16'h0);
    add(3, 1, 0, 0, 1, 16'h55, 0, 1, 0, 16'h0,  0);
    add(3, 1, 0, 0, 0, 16'h0,  0, 1, 0, 16'h0,  1);
    add(3, 1, 0, 0, 0, 16'h0,  0, 1, 0, 16'h0,  1);
    add(3, 1, 0, 0, 1, 16'h66, 0, 1, 1, 16'h55, 1);
    add(3, 1, 0, 0, 0, 16'h0,  0, 1, 1, 16'h55, 2);
    add(3, 1, 0, 0, 0, 16'h0,  0, 1, 1, 16'h55, 2);
    add(3, 1, 0, 0, 0, 16'h0,  1, 1, 1, 16'h55, 2);
    add(3, 1, 0, 0, 0, 16'h0,  1, 1, 1, 16'h66, 1);
    add(3, 1, 0, 0, 0, 16'h0,  1, 1, 0, 16'h66, 0);

    // Flush with a handshake on both sides, DEPTH=2: 0x3 is never stored and
    // the data registers keep 0x1 in the last slot.
    add_rst(2, 16'h0);
    add(2, 1, 0, 0, 1, 16'h1, 0, 1, 0, 16'h0, 0);
    add(2, 1, 0, 0, 1, 16'h2, 0, 1, 0, 16'h0, 1);
    add(2, 1, 0, 1, 1, 16'h3, 1, 1, 1, 16'h1, 2);
    add(2, 1, 0, 0, 0, 16'h0, 1, 1, 0, 16'h1, 0);
    add(2, 1, 0, 0, 0, 16'h0, 1, 1, 0, 16'h1, 0);

    // Reset mid-stall, DEPTH=4 with RESET_DATA=0xBEEF.
    add_rst(4, 16'hBEEF);
    add(4, 1, 0, 0, 1, 16'h21, 0, 1,    0, 16'hBEEF, 0);
    add(4, 1, 0, 0, 1, 16'h22, 0, 1,    0, 16'hBEEF, 1);
    add(4, 1, 0, 0, 1, 16'h23, 0, 1,    0, 16'hBEEF, 2);
    add(4, 1, 0, 0, 1, 16'h24, 0, 1,    0, 16'hBEEF, 3);
    add(4, 1, 0, 0, 1, 16'h25, 0, SKID, 1, 16'h21,   4);
    add(4, 1, 1, 0, 1, 16'h25, 0, 0,    1, 16'h21,   SKID ? 5 : 4);
    add(4, 1, 0, 0, 0, 16'h0,  0, 1,    0, 16'hBEEF, 0);

    // DEPTH=1: single handshake register, or register plus skid entry.
    add_rst(1, 16'h0);
    add(1, 1, 0, 0, 1, 16'h7, 0, 1,    0, 16'h0, 0);
    add(1, 1, 0, 0, 1, 16'h8, 0, SKID, 1, 16'h7, 1);
    if (SKID) begin
      add(1, 1, 0, 0, 0, 16'h0, 0, 0, 1, 16'h7, 2);
      add(1, 1, 0, 0, 0, 16'h0, 1, 0, 1, 16'h7, 2);
      add(1, 1, 0, 0, 0, 16'h0, 1, 1, 1, 16'h8, 1);
    end else begin
      add(1, 1, 0, 0, 1, 16'h8, 1, 1, 1, 16'h7, 1);
      add(1, 1, 0, 0, 0, 16'h0, 1, 1, 1, 16'h8, 1);
    end
    add(1, 1, 0, 0, 0, 16'h0, 1, 1, 0, 16'h8, 0);

    foreach (tbl[k]) begin
      @(negedge clk);
      rst       = tbl[k].rst;
      flush     = tbl[k].fl;
      in_valid  = tbl[k].iv;
      in_data   = tbl[k].id;
      out_ready = tbl[k].ordy;
      #1;
      if (tbl[k].chk) begin
        sample(tbl[k].sel, s_ir, s_ov, s_od, s_occ);
        check("in_ready",  k, 32'(s_ir),  32'(tbl[k].e_ir));
        check("out_valid", k, 32'(s_ov),  32'(tbl[k].e_ov));
        check("out_data",  k, 32'(s_od),  32'(tbl[k].e_od));
        check("occupancy", k, 32'(s_occ), 32'(tbl[k].e_occ));
      end
    end

    // Latency, DEPTH=4, no stall: a beat accepted at edge N must be visible
    // after edge N+3, i.e. at the 4th sample following the accept.
    @(negedge clk); rst = 1; flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk); rst = 0; in_valid = 1; in_data = 16'h77;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); in_valid = 0;
      #1;
      if (ov4 === 1'b1) begin lat = c; break; end
    end
    check("latency_d4", 0, 32'(lat), 32'd4);
    check("latency_d4_data", 0, 32'(od4), 32'h77);

    // Streaming scoreboard through DEPTH=3 with irregular valid/ready:
    // order, no loss and no duplication, bounded by a cycle budget.
    @(negedge clk); rst = 1; in_valid = 0; out_ready = 0;
    @(negedge clk); rst = 0;
    sent = 0; rcvd = 0;
    max_occ = SKID ? 4 : 3;
    for (int c = 0; c < 400 && rcvd < 20; c++) begin
      @(negedge clk);
      in_valid  = (sent < 20) && ((c % 3) != 0);
      in_data   = 16'h100 + 16'(sent);
      out_ready = ((c % 4) != 1) && ((c % 7) != 3);
      #1;
      check("occ_bound", c, 32'(int'(oc3) <= max_occ), 32'd1);
      if (ov3 && out_ready) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        check("stream_data", rcvd, 32'(od3), 32'(exp_d));
        rcvd++;
      end
      if (in_valid && ir3) begin
        sb.push_back(in_data);
        sent++;
      end
    end
    check("stream_count", 0, 32'(rcvd), 32'd20);
    @(negedge clk); in_valid = 0; out_ready = 0;
    #1;
    check("stream_empty", 0, 32'(oc3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed-field inter-stage registers between datapath stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Carries one packed payload bus through DEPTH register slots, each with its own valid bit, using a valid/ready handshake.
- Bubbles collapse, so a stall only propagates back once every slot ahead is full; flush kills all in-flight slots.
- Sits between any two datapath stages; the stage wrapper packs and unpacks its fields into DATA_W.

Parameters:
- DATA_W, 32: payload width in bits, 1..256.
- DEPTH, 1: number of register slots, 1..8.
- RESET_DATA, {DATA_W{1'b0}}: data value loaded into every slot on reset.
- CNT_W, $clog2(DEPTH+2): width of the occupancy output (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  invalidate every slot, including the skid entry when present.
- in_valid  in  1  upstream offers a payload.
- in_ready  out  1  block accepts this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  last slot holds a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload of the last slot.
- occupancy  out  CNT_W  number of valid entries held: slots plus skid entry.

Behaviour:
- Reset (rst=1 at a clock edge):
  - all slot valid bits = 0, all slot data = RESET_DATA, skid entry empty.
  - out_valid = 0, out_data = RESET_DATA, occupancy = 0, in_ready = 1 on the first cycle after reset.
  - rst overrides flush and every handshake in the same cycle; reset mid-transfer drops the payload silently.
- Slots are numbered 0 (input side) to DEPTH-1 (output side); v[i] and d[i] are the valid bit and data of slot i.
- Ready chain, combinational:
  - adv[DEPTH-1] = out_ready | ~v[DEPTH-1].
  - adv[i] = adv[i+1] | ~v[i].
- Transfers:
  - Slot i with adv[i]=1 loads from slot i-1 (slot 0 loads from the input source): v[i] <= v[i-1], d[i] <= d[i-1].
  - Data is only written when the incoming valid is 1. A bubble moving in clears v but leaves d unchanged, to save power.
  - Without the skid feature, in_ready = adv[0].
- Latency and throughput:
  - in_data accepted at edge N appears on out_data after edge N+DEPTH-1, i.e. registered latency DEPTH cycles, assuming no downstream stall.
  - Sustained throughput is 1 transfer per cycle.
- Output: out_valid = v[DEPTH-1], out_data = d[DEPTH-1], both registered with no combinational path from in_*.
- Full: all v = 1 and out_ready = 0 gives in_ready = 0. in_data is ignored while in_ready = 0.
- Empty: all v = 0 gives in_ready = 1 regardless of out_ready.
- Flush (flush=1, rst=0):
  - all v <= 0 and the skid entry is emptied at the edge; data registers keep their values.
  - A handshake on either side in the same cycle is discarded: the input beat is not stored and the output beat is not repeated.
  - Downstream may still sample out_valid/out_data during the flush cycle; discarding that beat is the consumer's responsibility.
  - occupancy = 0 the cycle after.
- Occupancy update: occupancy <= occupancy + (in_valid & in_ready) - (out_valid & out_ready), computed as the popcount of the next-state valid bits. It never exceeds DEPTH without the skid feature, or DEPTH+1 with it.
- DEPTH=1 degenerates to a single handshake register: in_ready = out_ready | ~out_valid.

Optional Feature:
- Macro PIPE_STAGE_SKID_BUF_EN.
- Defined:
  - One-entry skid register sits in front of slot 0, and in_ready = ~skid_valid is registered.
  - When in_valid & in_ready and adv[0]=0, the beat goes into the skid entry.
  - While the skid entry is full, slot 0 loads from it first; the skid entry then empties and in_ready returns to 1 the next cycle.
  - Ordering is preserved, there is no beat loss, and capacity is DEPTH+1.
  - Latency is unchanged when the skid entry is empty.
- Undefined: no skid register; in_ready is combinational from out_ready through the ready chain.

Test Plan:
- Reset and stream: rst=1 for 2 cycles, then DEPTH=3, out_ready=1, in_data 0x10,0x11,0x12 on consecutive cycles -> out_valid rises 3 cycles after the first accept; out_data 0x10,0x11,0x12 on consecutive cycles; occupancy peaks at 3.
- Backpressure: DEPTH=2, out_ready=0, push 0xA,0xB,0xC -> after 2 accepts in_ready=0, occupancy=2, out_data holds 0xA. Raise out_ready -> 0xA,0xB,0xC emerge in order with no duplicate.
- Bubble collapse: DEPTH=3, one beat 0x55 then in_valid=0 for 2 cycles, out_ready=0 -> 0x55 reaches slot 2; next push 0x66 still accepted (in_ready=1) and settles behind it.
- Flush with simultaneous handshake: DEPTH=2 full of 0x1,0x2, assert flush with in_valid=1 (0x3) and out_ready=1 -> next cycle out_valid=0, occupancy=0; 0x3 never appears at the output.
- Reset mid-stall: full DEPTH=4, out_ready=0, pulse rst -> next cycle out_valid=0, out_data=RESET_DATA, in_ready=1, occupancy=0.
- Skid (PIPE_STAGE_SKID_BUF_EN): DEPTH=1, out_ready=0, push 0x7 then 0x8 -> both accepted, in_ready=0, occupancy=2. Release out_ready -> 0x7 then 0x8 appear, and in_ready returns to 1 one cycle after the skid entry drains.
